// File: rtl/hdmi_fmt_pkg.sv
// Shared definitions for the HDMI output formatter: mode encodings and the
// constant colour-bar and ordered-dither tables.
package hdmi_fmt_pkg;

  typedef enum logic [1:0] {
    MODE_TRUNC  = 2'd0,
    MODE_DITHER = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_SOLID  = 2'd3
  } fmt_mode_e;

  localparam int PIX_CNT_W = 16;

  // White, yellow, cyan, green, magenta, red, blue, black as {R,G,B}.
  localparam logic [23:0] BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // 2x2 Bayer offset indexed by {y[0], x[0]}.
  localparam logic [1:0] BAYER [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

endpackage

// File: rtl/hdmi_fmt_pack.sv
// Pixel source selection, ordered dither and output packing. Purely
// combinational; sits between the two pipeline register stages of the top.
module hdmi_fmt_pack
  import hdmi_fmt_pkg::*;
#(
  parameter int OUT_WIDTH = 16
) (
  input  fmt_mode_e              mode,
  input  logic                   de,
  input  logic [23:0]            pix,
  input  logic [23:0]            solid,
  input  logic [2:0]             bar_idx,
  input  logic                   x0,
  input  logic                   y0,
  output logic [OUT_WIDTH-1:0]   px
);

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {6'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [1:0]  d;
  logic [23:0] rgb;

  always_comb begin
    d   = BAYER[{y0, x0}];
    rgb = pix;
    case (mode)
      MODE_DITHER: begin
        // Dither only matters when bits are discarded by the 565 packing.
        if (OUT_WIDTH == 16) begin
          rgb = {sat_add(pix[23:16], {d, 1'b0}),
                 sat_add(pix[15:8],  {1'b0, d}),
                 sat_add(pix[7:0],   {d, 1'b0})};
        end
      end
      MODE_BARS:  rgb = BAR_COLORS[bar_idx];
      MODE_SOLID: rgb = solid;
      default:    rgb = pix;
    endcase
  end

  generate
    if (OUT_WIDTH == 16) begin : g_rgb565
      logic unused_lsbs;
      assign unused_lsbs = ^{rgb[18:16], rgb[9:8], rgb[2:0]};
      assign px = de ? {rgb[23:19], rgb[15:10], rgb[7:3]} : '0;
    end else begin : g_rgb888
      assign px = de ? rgb : '0;
    end
  endgenerate

endmodule

// File: rtl/hdmi_out_fmt.sv
// HDMI output formatter: pixel/line counters, frame-aligned mode latch and a
// two-stage pipeline around the packing logic so every output lags by 2 clk.
module hdmi_out_fmt
  import hdmi_fmt_pkg::*;
#(
  parameter int OUT_WIDTH      = 16,
  parameter int BAR_WIDTH_LOG2 = 7,
  parameter int FCNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            mode,
  input  logic [23:0]           solid_color,
  input  logic [23:0]           in_data,
  input  logic                  in_de,
  input  logic                  in_hs,
  input  logic                  in_vs,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_de,
  output logic                  out_hs,
  output logic                  out_vs,
  output logic [FCNT_WIDTH-1:0] frame_cnt,
  output logic [1:0]            mode_active
);

  logic [PIX_CNT_W-1:0] x;
  logic [PIX_CNT_W-1:0] y;
  fmt_mode_e            mode_sel;

  logic [23:0]          data_p0;
  logic [23:0]          solid_p0;
  logic                 vld_p0;
  logic                 hs_p0;
  logic                 vs_p0;
  logic [2:0]           bar_p0;
  logic                 x0_p0;
  logic                 y0_p0;
  fmt_mode_e            mode_p0;

  logic [OUT_WIDTH-1:0] px_p0;
  logic [OUT_WIDTH-1:0] data_p1;
  logic                 vld_p1;
  logic                 hs_p1;
  logic                 vs_p1;

  logic                 vs_rise;
  logic                 de_fall;

  // vs_p0/vld_p0 double as the one-cycle-old copies for edge detection.
  assign vs_rise = in_vs & ~vs_p0;
  assign de_fall = ~in_de & vld_p0;

  // A vs rise clears the counters before the current de is counted, so a
  // pixel arriving together with vs is x=0 and the next one is x=1, y=0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x           <= '0;
      y           <= '0;
      frame_cnt   <= '0;
      mode_sel    <= MODE_TRUNC;
    end else begin
      if (vs_rise) begin
        x <= PIX_CNT_W'(in_de);
      end else if (in_de) begin
        x <= x + PIX_CNT_W'(1);
      end else begin
        x <= '0;
      end

      if (vs_rise) begin
        y <= '0;
      end else if (de_fall) begin
        y <= y + PIX_CNT_W'(1);
      end

      if (vs_rise) begin
        frame_cnt <= frame_cnt + FCNT_WIDTH'(1);
        mode_sel  <= fmt_mode_e'(mode);
      end
    end
  end

  assign mode_active = mode_sel;

  // Stage p0: capture the input pixel with its position and applied mode.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_p0  <= '0;
      solid_p0 <= '0;
      vld_p0   <= 1'b0;
      hs_p0    <= 1'b0;
      vs_p0    <= 1'b0;
      bar_p0   <= '0;
      x0_p0    <= 1'b0;
      y0_p0    <= 1'b0;
      mode_p0  <= MODE_TRUNC;
    end else begin
      data_p0  <= in_data;
      solid_p0 <= solid_color;
      vld_p0   <= in_de;
      hs_p0    <= in_hs;
      vs_p0    <= in_vs;
      bar_p0   <= x[BAR_WIDTH_LOG2 +: 3];
      x0_p0    <= x[0];
      y0_p0    <= y[0];
      mode_p0  <= mode_sel;
    end
  end

  hdmi_fmt_pack #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_pack (
    .mode    (mode_p0),
    .de      (vld_p0),
    .pix     (data_p0),
    .solid   (solid_p0),
    .bar_idx (bar_p0),
    .x0      (x0_p0),
    .y0      (y0_p0),
    .px      (px_p0)
  );

  // Stage p1: formatted pixel and timing, driving the outputs directly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      hs_p1   <= 1'b0;
      vs_p1   <= 1'b0;
    end else begin
      data_p1 <= px_p0;
      vld_p1  <= vld_p0;
      hs_p1   <= hs_p0;
      vs_p1   <= vs_p0;
    end
  end

  assign out_data = data_p1;
  assign out_de   = vld_p1;
  assign out_hs   = hs_p1;
  assign out_vs   = vs_p1;

endmodule

// File: tb/tb_hdmi_out_fmt.sv
// Directed bench for hdmi_out_fmt: an RGB565 instance and an RGB888 instance
// driven in parallel, with hand-computed expected pixels.
module tb_hdmi_out_fmt;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  mode;
  logic [23:0] solid_color;
  logic [23:0] in_data;
  logic        in_de, in_hs, in_vs;

  logic [15:0] out_data;
  logic        out_de, out_hs, out_vs;
  logic [3:0]  frame_cnt;
  logic [1:0]  mode_active;

  logic [23:0] out_data24;
  logic        out_de24, out_hs24, out_vs24;
  logic [15:0] frame_cnt24;
  logic [1:0]  mode_active24;

  int n_checks = 0;
  int n_errors = 0;

  logic        have_prev = 1'b0;
  logic        p_de, p_hs, p_vs;
  logic [15:0] p_e16;
  logic [23:0] p_e24;

  logic [15:0] bar16 [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [23:0] bar24 [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk = ~clk;

  hdmi_out_fmt #(
    .OUT_WIDTH      (16),
    .BAR_WIDTH_LOG2 (2),
    .FCNT_WIDTH     (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mode        (mode),
    .solid_color (solid_color),
    .in_data     (in_data),
    .in_de       (in_de),
    .in_hs       (in_hs),
    .in_vs       (in_vs),
    .out_data    (out_data),
    .out_de      (out_de),
    .out_hs      (out_hs),
    .out_vs      (out_vs),
    .frame_cnt   (frame_cnt),
    .mode_active (mode_active)
  );

  hdmi_out_fmt #(
    .OUT_WIDTH      (24),
    .BAR_WIDTH_LOG2 (2),
    .FCNT_WIDTH     (16)
  ) dut24 (
    .clk         (clk),
    .resetn      (resetn),
    .mode        (mode),
    .solid_color (solid_color),
    .in_data     (in_data),
    .in_de       (in_de),
    .in_hs       (in_hs),
    .in_vs       (in_vs),
    .out_data    (out_data24),
    .out_de      (out_de24),
    .out_hs      (out_hs24),
    .out_vs      (out_vs24),
    .frame_cnt   (frame_cnt24),
    .mode_active (mode_active24)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one input cycle, then check the outputs for the previous cycle's
  // pixel, which has now had two clock edges to reach the outputs.
  task automatic drive(input logic de, input logic hs, input logic vs,
                       input logic [23:0] d, input logic [15:0] e16, input logic [23:0] e24);
    in_de   = de;
    in_hs   = hs;
    in_vs   = vs;
    in_data = d;
    @(posedge clk);
    #1;
    if (have_prev) begin
      check_eq("out_de",     {31'd0, out_de},   {31'd0, p_de});
      check_eq("out_hs",     {31'd0, out_hs},   {31'd0, p_hs});
      check_eq("out_vs",     {31'd0, out_vs},   {31'd0, p_vs});
      check_eq("out_data16", {16'd0, out_data}, {16'd0, p_e16});
      check_eq("out_de24",   {31'd0, out_de24}, {31'd0, p_de});
      check_eq("out_hs24",   {31'd0, out_hs24}, {31'd0, p_hs});
      check_eq("out_vs24",   {31'd0, out_vs24}, {31'd0, p_vs});
      check_eq("out_data24", {8'd0, out_data24}, {8'd0, p_e24});
    end
    p_de      = de;
    p_hs      = hs;
    p_vs      = vs;
    p_e16     = e16;
    p_e24     = e24;
    have_prev = 1'b1;
  endtask

  task automatic idle(input logic hs, input logic vs);
    drive(1'b0, hs, vs, 24'hFFFFFF, 16'h0000, 24'h000000);
  endtask

  task automatic vs_pulse();
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
  endtask

  initial begin
    resetn      = 1'b0;
    mode        = 2'd0;
    solid_color = 24'h000000;
    in_data     = 24'h000000;
    in_de       = 1'b0;
    in_hs       = 1'b0;
    in_vs       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data",  {16'd0, out_data},     32'd0);
    check_eq("rst_de",    {31'd0, out_de},       32'd0);
    check_eq("rst_fcnt",  {28'd0, frame_cnt},    32'd0);
    check_eq("rst_mode",  {30'd0, mode_active},  32'd0);
    resetn = 1'b1;

    // Mode 0 truncation.
    vs_pulse();
    check_eq("fcnt_1", {28'd0, frame_cnt}, 32'd1);
    check_eq("mode_0", {30'd0, mode_active}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 24'hFF8040, 16'hFC08, 24'hFF8040);
    drive(1'b1, 1'b1, 1'b0, 24'h123456, 16'h11AA, 24'h123456);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);

    // Mode 1 ordered dither across three lines.
    mode = 2'd1;
    vs_pulse();
    check_eq("fcnt_2", {28'd0, frame_cnt}, 32'd2);
    check_eq("mode_1", {30'd0, mode_active}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 24'h7C7C7C, 16'h7BEF, 24'h7C7C7C);
    drive(1'b1, 1'b0, 1'b0, 24'h7C7C7C, 16'h83F0, 24'h7C7C7C);
    idle(1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 24'h7C7C7C, 16'h83F0, 24'h7C7C7C);
    drive(1'b1, 1'b0, 1'b0, 24'h7C7C7C, 16'h7BEF, 24'h7C7C7C);
    drive(1'b1, 1'b0, 1'b0, 24'hFFFFFF, 16'hFFFF, 24'hFFFFFF);
    idle(1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 24'h000000, 16'h0000, 24'h000000);
    idle(1'b1, 1'b0);
    // de and vs rise together on an odd line: next pixel must be x=1, y=0.
    drive(1'b1, 1'b0, 1'b1, 24'h7C7C7C, 16'h83F0, 24'h7C7C7C);
    drive(1'b1, 1'b0, 1'b0, 24'h7C7C7C, 16'h83F0, 24'h7C7C7C);
    idle(1'b0, 1'b0);
    check_eq("fcnt_3", {28'd0, frame_cnt}, 32'd3);

    // Mode 2 colour bars, 4-pixel bars over a 40-pixel line.
    mode = 2'd2;
    vs_pulse();
    check_eq("fcnt_4", {28'd0, frame_cnt}, 32'd4);
    check_eq("mode_2", {30'd0, mode_active}, 32'd2);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 1'b0, 24'hA5A5A5, bar16[(i >> 2) & 7], bar24[(i >> 2) & 7]);
    end
    idle(1'b0, 1'b0);

    // Mode change mid-frame is deferred to the next vs.
    mode = 2'd0;
    vs_pulse();
    check_eq("fcnt_5", {28'd0, frame_cnt}, 32'd5);
    drive(1'b1, 1'b0, 1'b0, 24'hFF8040, 16'hFC08, 24'hFF8040);
    mode = 2'd2;
    drive(1'b1, 1'b0, 1'b0, 24'hFF8040, 16'hFC08, 24'hFF8040);
    idle(1'b0, 1'b0);
    check_eq("mode_held", {30'd0, mode_active}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 24'h123456, 16'h11AA, 24'h123456);
    idle(1'b0, 1'b0);
    vs_pulse();
    check_eq("fcnt_6", {28'd0, frame_cnt}, 32'd6);
    check_eq("mode_2b", {30'd0, mode_active}, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 24'hFF8040, 16'hFFFF, 24'hFFFFFF);
    idle(1'b0, 1'b0);

    // Mode 3 solid colour, then reset in the middle of the line.
    mode        = 2'd3;
    solid_color = 24'h123456;
    vs_pulse();
    check_eq("fcnt_7", {28'd0, frame_cnt}, 32'd7);
    drive(1'b1, 1'b1, 1'b0, 24'hFF8040, 16'h11AA, 24'h123456);
    drive(1'b1, 1'b1, 1'b0, 24'h7C7C7C, 16'h11AA, 24'h123456);
    drive(1'b1, 1'b0, 1'b0, 24'hFF8040, 16'h11AA, 24'h123456);
    check_eq("pre_rst_de", {31'd0, out_de}, 32'd1);
    resetn = 1'b0;
    in_de  = 1'b0;
    in_hs  = 1'b0;
    #1;
    check_eq("mid_rst_data",   {16'd0, out_data},    32'd0);
    check_eq("mid_rst_de",     {31'd0, out_de},      32'd0);
    check_eq("mid_rst_hs",     {31'd0, out_hs},      32'd0);
    check_eq("mid_rst_fcnt",   {28'd0, frame_cnt},   32'd0);
    check_eq("mid_rst_mode",   {30'd0, mode_active}, 32'd0);
    check_eq("mid_rst_data24", {8'd0, out_data24},   32'd0);
    have_prev = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 24'hFF8040, 16'hFC08, 24'hFF8040);
    drive(1'b1, 1'b0, 1'b0, 24'h123456, 16'h11AA, 24'h123456);
    idle(1'b0, 1'b0);
    vs_pulse();
    check_eq("fcnt_r1", {28'd0, frame_cnt}, 32'd1);
    check_eq("mode_3",  {30'd0, mode_active}, 32'd3);
    drive(1'b1, 1'b0, 1'b0, 24'hFF8040, 16'h11AA, 24'h123456);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // Frame counter wrap on the 4-bit instance.
    for (int i = 0; i < 14; i++) begin
      vs_pulse();
    end
    check_eq("fcnt_max",  {28'd0, frame_cnt}, 32'd15);
    vs_pulse();
    check_eq("fcnt_wrap", {28'd0, frame_cnt}, 32'd0);
    check_eq("fcnt24",    {16'd0, frame_cnt24}, 32'd16);
    check_eq("mode24",    {30'd0, mode_active24}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
